// File: rtl/bsg_zynq_axil_pkg.sv
// Shared types for the PL-side AXI4-Lite initiator.
//   state_e     : transaction sequencer states
//   RESP_*      : AXI response codes
//   axil_cmd_s  : captured command (we, addr, data, wstrb)
//   resp_is_err : anything other than OKAY is reported as an error
package bsg_zynq_axil_pkg;

    localparam int AXIL_DATA_WIDTH = 32;
    localparam int AXIL_ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WB,
        RA,
        RD,
        RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic                           we;
        logic [AXIL_ADDR_WIDTH-1:0]     addr;
        logic [AXIL_DATA_WIDTH-1:0]     data;
        logic [AXIL_DATA_WIDTH/8-1:0]   wstrb;
    } axil_cmd_s;

    // EXOKAY is flagged too: a lite initiator never issues exclusive accesses.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with asynchronous active-low reset to zero.
//   clk, rst_n : clock and async active-low reset
//   en         : load enable
//   d, q       : data in / registered data out
module bsg_dff_reset_en #(
    parameter int width_p = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [width_p-1:0] d,
    output logic [width_p-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/bsg_zynq_axil_master.sv
// PL-side AXI4-Lite initiator. Converts a valid/ready command stream into
// single AXI4-Lite reads or writes, one outstanding at a time, and returns
// each result on a valid/yumi response stream.
//   aclk, aresetn            : clock, async active-low reset
//   cmd_*                    : command stream (we, byte addr, data, wstrb)
//   resp_*                   : response stream (we echo, read data, error)
//   m00_axi_*                : AXI4-Lite master port
//
// state | meaning
// IDLE  | ready for a command
// WR    | AW and W offered; each drops after its own handshake
// WB    | waiting for the write response
// RA    | AR offered
// RD    | waiting for the read data
// RESP  | result held on resp_* until yumi
module bsg_zynq_axil_master
    import bsg_zynq_axil_pkg::*;
#(
    parameter int C_M00_AXI_DATA_WIDTH = AXIL_DATA_WIDTH,
    parameter int C_M00_AXI_ADDR_WIDTH = AXIL_ADDR_WIDTH
) (
    input  logic                              aclk,
    input  logic                              aresetn,

    input  logic                              cmd_v_i,
    output logic                              cmd_ready_o,
    input  logic                              cmd_we_i,
    input  logic [C_M00_AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]   cmd_data_i,
    input  logic [C_M00_AXI_DATA_WIDTH/8-1:0] cmd_wstrb_i,

    output logic                              resp_v_o,
    input  logic                              resp_yumi_i,
    output logic                              resp_we_o,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]   resp_data_o,
    output logic                              resp_err_o,

    output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [2:0]                        m00_axi_awprot,
    output logic                              m00_axi_awvalid,
    input  logic                              m00_axi_awready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                              m00_axi_wvalid,
    input  logic                              m00_axi_wready,
    input  logic [1:0]                        m00_axi_bresp,
    input  logic                              m00_axi_bvalid,
    output logic                              m00_axi_bready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [2:0]                        m00_axi_arprot,
    output logic                              m00_axi_arvalid,
    input  logic                              m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]                        m00_axi_rresp,
    input  logic                              m00_axi_rvalid,
    output logic                              m00_axi_rready
);

    // axil_cmd_s is sized from the package widths, which the parameter
    // defaults track; overriding the widths needs a matching package.
    state_e    state, state_next;
    axil_cmd_s cmd_d, cmd_q;
    logic      accept;
    logic      aw_hs, w_hs;
    logic      aw_done, w_done;

    assign accept = cmd_v_i & cmd_ready_o;
    assign aw_hs  = m00_axi_awvalid & m00_axi_awready;
    assign w_hs   = m00_axi_wvalid & m00_axi_wready;

    always_comb begin
        cmd_d       = '0;
        cmd_d.we    = cmd_we_i;
        cmd_d.addr  = cmd_addr_i;
        cmd_d.data  = cmd_data_i;
        cmd_d.wstrb = cmd_wstrb_i;
    end

    bsg_dff_reset_en #(.width_p($bits(axil_cmd_s))) cmd_reg (
        .clk   (aclk),
        .rst_n (aresetn),
        .en    (accept),
        .d     (cmd_d),
        .q     (cmd_q)
    );

    // Address/data come straight from the command register, which only
    // loads in IDLE, so they are stable for the whole transaction.
    assign m00_axi_awaddr = cmd_q.addr;
    assign m00_axi_araddr = cmd_q.addr;
    assign m00_axi_wdata  = cmd_q.data;
    assign m00_axi_wstrb  = cmd_q.wstrb;
    assign m00_axi_awprot = 3'b000;
    assign m00_axi_arprot = 3'b000;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // AW and W may complete in either order or together.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (accept) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (state == WR) begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            resp_we_o   <= 1'b0;
            resp_data_o <= '0;
            resp_err_o  <= 1'b0;
        end else if (state == WB && m00_axi_bvalid) begin
            resp_we_o   <= cmd_q.we;
            resp_data_o <= '0;
            resp_err_o  <= resp_is_err(m00_axi_bresp);
        end else if (state == RD && m00_axi_rvalid) begin
            resp_we_o   <= cmd_q.we;
            resp_data_o <= m00_axi_rdata;
            resp_err_o  <= resp_is_err(m00_axi_rresp);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = cmd_we_i ? WR : RA;
            WR:   if ((aw_done | aw_hs) & (w_done | w_hs)) state_next = WB;
            WB:   if (m00_axi_bvalid) state_next = RESP;
            RA:   if (m00_axi_arready) state_next = RD;
            RD:   if (m00_axi_rvalid) state_next = RESP;
            RESP: if (resp_yumi_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Every handshake output decodes registered state only, so no valid
    // ever follows a ready combinationally and reset clears them at once.
    always_comb begin
        cmd_ready_o     = 1'b0;
        m00_axi_awvalid = 1'b0;
        m00_axi_wvalid  = 1'b0;
        m00_axi_bready  = 1'b0;
        m00_axi_arvalid = 1'b0;
        m00_axi_rready  = 1'b0;
        resp_v_o        = 1'b0;
        case (state)
            IDLE: cmd_ready_o = 1'b1;
            WR: begin
                m00_axi_awvalid = ~aw_done;
                m00_axi_wvalid  = ~w_done;
            end
            WB:   m00_axi_bready  = 1'b1;
            RA:   m00_axi_arvalid = 1'b1;
            RD:   m00_axi_rready  = 1'b1;
            RESP: resp_v_o        = 1'b1;
            default: cmd_ready_o  = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_bsg_zynq_axil_master.sv
module tb_bsg_zynq_axil_master;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SW = DW / 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cmd_v, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [SW-1:0] cmd_wstrb;
    logic          resp_v, resp_yumi, resp_we, resp_err;
    logic [DW-1:0] resp_data;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    always #5 aclk = ~aclk;

    bsg_zynq_axil_master dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_wstrb_i(cmd_wstrb),
        .resp_v_o(resp_v), .resp_yumi_i(resp_yumi), .resp_we_o(resp_we),
        .resp_data_o(resp_data), .resp_err_o(resp_err),
        .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot),
        .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
        .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
        .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
        .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
        .m00_axi_araddr(araddr), .m00_axi_arprot(arprot),
        .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
        .m00_axi_rdata(rdata), .m00_axi_rresp(rresp),
        .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Per-transaction slave behaviour chosen by the stimulus.
    typedef struct {
        int         aw_wait;
        int         w_wait;
        int         b_wait;
        int         ar_wait;
        int         r_wait;
        logic [1:0] resp;
        logic [31:0] rdata;
        bit         early_r;
    } plan_t;

    plan_t        plan;
    logic [31:0]  slv_mem [8];
    logic [31:0]  ref_mem [8];
    logic [AW-1:0] exp_addr;
    logic [31:0]  exp_wdata;
    logic [3:0]   exp_wstrb;
    int aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0, r_hs_cnt = 0;
    int awv_cycles = 0, wv_cycles = 0;

    task automatic tick;
        @(negedge aclk);
        #1;
    endtask

    task automatic set_plan(input int aw_w, input int w_w, input int b_w, input int ar_w,
                            input int r_w, input logic [1:0] rsp, input logic [31:0] rd,
                            input bit early);
        plan.aw_wait = aw_w; plan.w_wait = w_w; plan.b_wait = b_w;
        plan.ar_wait = ar_w; plan.r_wait = r_w; plan.resp = rsp;
        plan.rdata = rd;     plan.early_r = early;
    endtask

    // AXI4-Lite slave: memory of 8 words, driven at the falling edge.
    // DUT outputs only change at the rising edge, so what is seen here
    // is what the next rising edge sees.
    initial begin : slave_model
        bit awv_q, wv_q, arv_q, bry_q, rry_q;
        bit aw_seen, w_seen, ar_seen, aw_got, w_got, ar_got, b_issued, r_issued;
        int aw_c, w_c, ar_c, b_c, r_c;
        logic [AW-1:0] a_addr;
        logic [31:0]   a_wd;
        logic [3:0]    a_ws;
        awv_q = 0; wv_q = 0; arv_q = 0; bry_q = 0; rry_q = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0; aw_got = 0; w_got = 0; ar_got = 0;
        b_issued = 0; r_issued = 0;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
        a_addr = '0; a_wd = '0; a_ws = '0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                arready = 0; rvalid = 0; rresp = 0; rdata = 0;
                awv_q = 0; wv_q = 0; arv_q = 0; bry_q = 0; rry_q = 0;
                aw_seen = 0; w_seen = 0; ar_seen = 0; aw_got = 0; w_got = 0; ar_got = 0;
                b_issued = 0; r_issued = 0;
                continue;
            end
            if (awvalid) awv_cycles++;
            if (wvalid)  wv_cycles++;

            if (awv_q && awready) begin
                aw_got = 1; a_addr = awaddr; aw_hs_cnt++;
                chk("awaddr", awaddr, exp_addr);
                chk("awprot", awprot, 3'b000);
            end
            if (wv_q && wready) begin
                w_got = 1; a_wd = wdata; a_ws = wstrb; w_hs_cnt++;
                chk("wdata", wdata, exp_wdata);
                chk("wstrb", wstrb, exp_wstrb);
            end
            if (bvalid && bry_q) begin
                bvalid = 0; b_hs_cnt++;
                aw_seen = 0; w_seen = 0; aw_got = 0; w_got = 0; b_issued = 0;
            end
            if (arv_q && arready) begin
                ar_got = 1; ar_hs_cnt++;
                chk("araddr", araddr, exp_addr);
                chk("arprot", arprot, 3'b000);
                if (r_issued) chk("early_rready_next", rready, 1'b1);
            end
            if (rvalid && rry_q) begin
                rvalid = 0; r_hs_cnt++;
                ar_seen = 0; ar_got = 0; r_issued = 0;
            end

            awready = 0;
            if (awvalid && !aw_got) begin
                if (!aw_seen) begin aw_seen = 1; aw_c = plan.aw_wait; b_c = plan.b_wait; end
                if (aw_c == 0) awready = 1; else aw_c--;
            end
            wready = 0;
            if (wvalid && !w_got) begin
                if (!w_seen) begin w_seen = 1; w_c = plan.w_wait; end
                if (w_c == 0) wready = 1; else w_c--;
            end
            if (aw_got && w_got && !b_issued) begin
                if (b_c == 0) begin
                    b_issued = 1; bvalid = 1; bresp = plan.resp;
                    if (plan.resp == 2'b00)
                        for (int i = 0; i < 4; i++)
                            if (a_ws[i]) slv_mem[a_addr[4:2]][8*i +: 8] = a_wd[8*i +: 8];
                end else b_c--;
            end
            arready = 0;
            if (arvalid && !ar_got) begin
                if (!ar_seen) begin ar_seen = 1; ar_c = plan.ar_wait; r_c = plan.r_wait; end
                if (ar_c == 0) begin
                    arready = 1;
                    if (plan.early_r) begin
                        r_issued = 1; rvalid = 1; rresp = plan.resp;
                        rdata = (plan.resp == 2'b00) ? slv_mem[araddr[4:2]] : plan.rdata;
                        chk("early_rready_low", rready, 1'b0);
                    end
                end else ar_c--;
            end
            if (ar_got && !r_issued) begin
                if (r_c == 0) begin
                    r_issued = 1; rvalid = 1; rresp = plan.resp;
                    rdata = (plan.resp == 2'b00) ? slv_mem[araddr[4:2]] : plan.rdata;
                end else r_c--;
            end
            awv_q = awvalid; wv_q = wvalid; arv_q = arvalid; bry_q = bready; rry_q = rready;
        end
    end

    // Called just after a falling edge; returns one falling edge after accept.
    task automatic send_cmd(input bit we, input logic [AW-1:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        bit ok;
        exp_addr = addr; exp_wdata = data; exp_wstrb = strb;
        cmd_v = 1; cmd_we = we; cmd_addr = addr; cmd_data = data; cmd_wstrb = strb;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin ok = 1; tick; break; end
            tick;
        end
        cmd_v = 0;
        if (!ok) chk("cmd_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_txn(input bit we, input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int yumi_delay, input bit hold_cmd);
        logic [31:0] exp_data;
        bit          exp_err, got;
        int          exp_lat, lat;
        exp_err = plan.resp != 2'b00;
        if (we) begin
            exp_data = 0;
            exp_lat  = ((plan.aw_wait > plan.w_wait) ? plan.aw_wait : plan.w_wait)
                       + plan.b_wait + 3;
        end else begin
            exp_data = exp_err ? plan.rdata : ref_mem[addr[4:2]];
            exp_lat  = plan.ar_wait + (plan.early_r ? 0 : plan.r_wait) + 3;
        end
        send_cmd(we, addr, data, strb);
        if (we && !exp_err)
            for (int i = 0; i < 4; i++)
                if (strb[i]) ref_mem[addr[4:2]][8*i +: 8] = data[8*i +: 8];
        lat = 1; got = 0;
        for (int i = 0; i < 200; i++) begin
            if (resp_v) begin got = 1; break; end
            tick; lat++;
        end
        chk("resp_arrived", got, 1'b1);
        chk("resp_latency", lat, exp_lat);
        chk("resp_we", resp_we, we);
        chk("resp_data", resp_data, exp_data);
        chk("resp_err", resp_err, exp_err);
        if (hold_cmd) begin
            cmd_v = 1; cmd_we = $urandom_range(0, 1); cmd_addr = AW'($urandom);
        end
        for (int k = 0; k < yumi_delay; k++) begin
            tick;
            chk("hold_resp_v", resp_v, 1'b1);
            chk("hold_resp_data", resp_data, exp_data);
            chk("hold_resp_err", resp_err, exp_err);
            chk("hold_resp_we", resp_we, we);
            chk("hold_cmd_ready", cmd_ready, 1'b0);
            chk("hold_no_aw_ar", {awvalid, arvalid}, 2'b00);
        end
        resp_yumi = 1;
        tick;
        resp_yumi = 0;
        cmd_v = 0;
        chk("resp_v_after_yumi", resp_v, 1'b0);
        chk("cmd_ready_after_yumi", cmd_ready, 1'b1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int b0, aw0, ar0;
        bit we;
        logic [1:0] rsp;
        cmd_v = 0; cmd_we = 0; cmd_addr = 0; cmd_data = 0; cmd_wstrb = 0; resp_yumi = 0;
        set_plan(0, 0, 0, 0, 0, 2'b00, 0, 0);
        for (int i = 0; i < 8; i++) begin
            slv_mem[i] = $urandom;
            ref_mem[i] = slv_mem[i];
        end

        #2;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, resp_v}, 6'b0);
        chk("rst_resp_fields", {resp_we, resp_err, resp_data}, '0);
        chk("rst_addr_data", {awaddr, wdata, wstrb}, '0);
        tick; tick;
        aresetn = 1;
        tick;

        // loopback write then read
        set_plan(0, 0, 0, 0, 0, 2'b00, 0, 0);
        run_txn(1, 5'h00, 32'hDEADBEEF, 4'hF, 0, 0);
        run_txn(0, 5'h00, 32'h0, 4'h0, 0, 0);
        chk("loopback_data", resp_data, 32'hDEADBEEF);

        // skewed readies: AW held off three cycles, W immediate
        awv_cycles = 0; wv_cycles = 0; b0 = b_hs_cnt;
        set_plan(3, 0, 0, 0, 0, 2'b00, 0, 0);
        run_txn(1, 5'h04, 32'h0BADF00D, 4'h5, 1, 0);
        chk("skew_awvalid_cycles", awv_cycles, 4);
        chk("skew_wvalid_cycles", wv_cycles, 1);
        chk("skew_b_handshakes", b_hs_cnt - b0, 1);

        // error responses
        set_plan(0, 0, 0, 0, 0, 2'b10, 0, 0);
        run_txn(1, 5'h0C, 32'h11112222, 4'hF, 0, 0);
        set_plan(0, 0, 0, 0, 0, 2'b11, 32'h1234, 0);
        run_txn(0, 5'h0C, 32'h0, 4'h0, 0, 0);
        set_plan(0, 0, 0, 0, 0, 2'b01, 32'h55AA, 0);
        run_txn(0, 5'h10, 32'h0, 4'h0, 0, 0);

        // backpressure with a command waiting
        aw0 = aw_hs_cnt; ar0 = ar_hs_cnt;
        set_plan(0, 0, 0, 0, 0, 2'b00, 0, 0);
        run_txn(1, 5'h14, 32'hA5A5_5A5A, 4'hF, 10, 1);
        chk("bp_aw_count", aw_hs_cnt - aw0, 1);
        chk("bp_ar_count", ar_hs_cnt - ar0, 0);
        run_txn(0, 5'h14, 32'h0, 4'h0, 0, 0);

        // early read data, offered together with arready
        set_plan(0, 0, 0, 0, 0, 2'b00, 0, 1);
        run_txn(0, 5'h00, 32'h0, 4'h0, 0, 0);
        set_plan(0, 0, 0, 2, 0, 2'b00, 0, 1);
        run_txn(0, 5'h04, 32'h0, 4'h0, 0, 0);

        // reset while AW is pending and W has completed
        b0 = b_hs_cnt;
        set_plan(10, 0, 0, 0, 0, 2'b00, 0, 0);
        send_cmd(1, 5'h08, 32'hCAFEF00D, 4'hF);
        tick;
        chk("rst_mid_pre_awvalid", awvalid, 1'b1);
        chk("rst_mid_pre_wvalid", wvalid, 1'b0);
        aresetn = 0;
        #1;
        chk("rst_mid_awvalid", awvalid, 1'b0);
        chk("rst_mid_cmd_ready", cmd_ready, 1'b1);
        tick; tick;
        aresetn = 1;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk("rst_after_idle", {cmd_ready, resp_v, awvalid, wvalid, bready}, 5'b10000);
        end
        chk("rst_no_b", b_hs_cnt - b0, 0);

        // randomized traffic against the memory model
        for (int t = 0; t < 40; t++) begin
            we  = 1'($urandom_range(0, 1));
            rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            set_plan($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                     $urandom_range(0, 3), $urandom_range(0, 2), rsp, $urandom,
                     !we && ($urandom_range(0, 1) == 1));
            run_txn(we, AW'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
